timer_ctrl: RTL and testbench

TIMER_CTRL -- requirements
Module: timer_ctrl

---
 rtl/timer_pkg.sv | 13 +
 rtl/bcd_dec3.sv | 18 +
 rtl/timer_ctrl.sv | 111 +++++++++++
 tb/tb_timer_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding, default prescale and digit clamp for timer_ctrl
package timer_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;
  localparam int unsigned TICK_DIV_DEFAULT = 50000000;
  function automatic logic [3:0] clamp9(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction
endpackage

// File: rtl/bcd_dec3.sv
// bcd_dec3: combinational 3-digit BCD decrement with zero flag on the result
//   bcd_i  : {hundreds, tens, units} input count
//   bcd_o  : count minus one in BCD, saturating at 000
//   zero_o : high when bcd_o is 000
module bcd_dec3 (
  input  logic [11:0] bcd_i,
  output logic [11:0] bcd_o,
  output logic        zero_o
);
  logic bu, bt;
  assign bu = bcd_i[3:0] == 4'd0;
  assign bt = bu & (bcd_i[7:4] == 4'd0);
  assign bcd_o = (bcd_i == 12'h000) ? 12'h000 :
                 {bt ? bcd_i[11:8] - 4'd1 : bcd_i[11:8],
                  bt ? 4'd9 : (bu ? bcd_i[7:4] - 4'd1 : bcd_i[7:4]),
                  bu ? 4'd9 : bcd_i[3:0] - 4'd1};
  assign zero_o = bcd_o == 12'h000;
endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: 3-digit BCD countdown timer with start/pause/clear/preset buttons
//   CLK, RST_N              : clock, asynchronous active-low reset
//   START/STOP/CLEAR/LOAD   : level buttons, acted on at their rising edge only
//   PRESET                  : BCD preset {hundreds, tens, units}
//   units/tens/hundreds     : registered BCD count
//   RUNNING / DONE          : registered state flags for RUN / EXPIRED
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic        STOP,
  input  logic        CLEAR,
  input  logic        LOAD,
  input  logic [11:0] PRESET,
  output logic [3:0]  units,
  output logic [3:0]  tens,
  output logic [3:0]  hundreds,
  output logic        RUNNING,
  output logic        DONE
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  state_t        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [11:0]   cnt_q, cnt_d, dec;
  logic          start_q, stop_q, clear_q, load_q;
  logic          running_q, running_d, done_q, done_d;
  logic          dec_zero, tick;
  logic          ev_clear, ev_stop, ev_start, ev_load;
  // Only the highest-priority edge of the cycle acts.
  assign ev_clear = CLEAR & ~clear_q;
  assign ev_stop  = STOP & ~stop_q & ~ev_clear;
  assign ev_start = START & ~start_q & ~ev_clear & ~(STOP & ~stop_q);
  assign ev_load  = LOAD & ~load_q & ~ev_clear & ~(STOP & ~stop_q) & ~(START & ~start_q);
  assign tick     = pre_q == PRE_MAX;
  bcd_dec3 u_dec (
    .bcd_i  (cnt_q),
    .bcd_o  (dec),
    .zero_o (dec_zero)
  );
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    if (ev_clear) begin
      state_d = IDLE;
      pre_d   = '0;
      cnt_d   = 12'h000;
    end else begin
      case (state_q)
        IDLE: begin
          if (ev_start && cnt_q != 12'h000) begin
            state_d = RUN;
            pre_d   = '0;
          end else if (ev_load) begin
            cnt_d = {clamp9(PRESET[11:8]), clamp9(PRESET[7:4]), clamp9(PRESET[3:0])};
          end
        end
        RUN: begin
          // A tick landing on the STOP edge is dropped; prescaler freezes as-is.
          if (ev_stop) begin
            state_d = PAUSE;
          end else if (tick) begin
            pre_d = '0;
            cnt_d = dec;
            if (dec_zero) state_d = EXPIRED;
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end
        PAUSE:   if (ev_start) state_d = RUN;
        EXPIRED: if (ev_start) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    running_d = state_d == RUN;
    done_d    = state_d == EXPIRED;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      cnt_q     <= 12'h000;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      clear_q   <= 1'b0;
      load_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      start_q   <= START;
      stop_q    <= STOP;
      clear_q   <= CLEAR;
      load_q    <= LOAD;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end
  assign units    = cnt_q[3:0];
  assign tens     = cnt_q[7:4];
  assign hundreds = cnt_q[11:8];
  assign RUNNING  = running_q;
  assign DONE     = done_q;
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: scenario bench for timer_ctrl with TICK_DIV = 4
module tb_timer_ctrl;
  logic        CLK = 1'b0, RST_N = 1'b0;
  logic        START = 1'b0, STOP = 1'b0, CLEAR = 1'b0, LOAD = 1'b0;
  logic [11:0] PRESET = 12'h000;
  logic [3:0]  units, tens, hundreds;
  logic        RUNNING, DONE;
  logic [11:0] cnt;
  logic [1:0]  fl;
  int total = 0, passed = 0;
  typedef struct {
    logic [11:0] cnt;
    logic [1:0]  fl;
    int          dly;
  } exp_t;
  exp_t q[$];
  timer_ctrl #(.TICK_DIV(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP), .CLEAR(CLEAR),
    .LOAD(LOAD), .PRESET(PRESET), .units(units), .tens(tens),
    .hundreds(hundreds), .RUNNING(RUNNING), .DONE(DONE)
  );
  assign cnt = {hundreds, tens, units};
  assign fl  = {RUNNING, DONE};
  always #5 CLK = ~CLK;
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  // Steps until the visible count/flags change or the budget runs out.
  task automatic wait_change(input int budget, output int cyc, output bit to);
    logic [13:0] s;
    s   = {cnt, fl};
    cyc = 0;
    to  = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick();
      cyc++;
      if ({cnt, fl} !== s) begin
        to = 1'b0;
        break;
      end
    end
  endtask
  task automatic load(input logic [11:0] p);
    PRESET = p;
    LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    tick();
  endtask
  task automatic press_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask
  task automatic press_clear();
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    tick();
  endtask
  task automatic test_reset();
    #12;
    total++; if (cnt !== 12'h000) $display("FAIL reset_cnt: got %h exp 000", cnt); else passed++;
    total++; if (fl !== 2'b00) $display("FAIL reset_flags: got %b exp 00", fl); else passed++;
    RST_N = 1'b1;
    tick();
    tick();
  endtask
  task automatic test_load_run();
    exp_t e;
    int c;
    bit to;
    load(12'h012);
    total++; if (cnt !== 12'h012) $display("FAIL load_012: got %h exp 012", cnt); else passed++;
    press_start();
    total++; if (fl !== 2'b10) $display("FAIL run_flag: got %b exp 10", fl); else passed++;
    q.push_back('{12'h011, 2'b10, 4});
    q.push_back('{12'h010, 2'b10, 4});
    q.push_back('{12'h009, 2'b10, 4});
    while (q.size() > 0) begin
      e = q.pop_front();
      wait_change(e.dly + 8, c, to);
      total++;
      if (to || c != e.dly || cnt !== e.cnt || fl !== e.fl)
        $display("FAIL count_step: got %h fl %b after %0d (timeout %0b) exp %h fl %b after %0d", cnt, fl, c, to, e.cnt, e.fl, e.dly);
      else passed++;
    end
    press_clear();
    total++; if ({cnt, fl} !== 14'h0) $display("FAIL clear_run: got %h fl %b exp 000 fl 00", cnt, fl); else passed++;
  endtask
  task automatic test_expire();
    exp_t e;
    int c;
    bit to;
    load(12'h002);
    press_start();
    q.push_back('{12'h001, 2'b10, 4});
    q.push_back('{12'h000, 2'b01, 4});
    while (q.size() > 0) begin
      e = q.pop_front();
      wait_change(e.dly + 8, c, to);
      total++;
      if (to || c != e.dly || cnt !== e.cnt || fl !== e.fl)
        $display("FAIL expire_step: got %h fl %b after %0d (timeout %0b) exp %h fl %b after %0d", cnt, fl, c, to, e.cnt, e.fl, e.dly);
      else passed++;
    end
    wait_change(10, c, to);
    total++; if (!to || cnt !== 12'h000 || fl !== 2'b01) $display("FAIL expire_hold: got %h fl %b exp 000 fl 01", cnt, fl); else passed++;
    press_start();
    total++; if (cnt !== 12'h000 || fl !== 2'b00) $display("FAIL expire_to_idle: got %h fl %b exp 000 fl 00", cnt, fl); else passed++;
  endtask
  task automatic test_pause();
    exp_t e;
    int c;
    bit to;
    load(12'h050);
    press_start();
    tick();
    tick();
    STOP = 1'b1;
    tick();
    total++; if (cnt !== 12'h050 || fl !== 2'b00) $display("FAIL pause_enter: got %h fl %b exp 050 fl 00", cnt, fl); else passed++;
    wait_change(20, c, to);
    total++; if (!to) $display("FAIL pause_frozen: got %h fl %b exp 050 fl 00", cnt, fl); else passed++;
    STOP = 1'b0;
    press_start();
    total++; if (fl !== 2'b10) $display("FAIL resume_flag: got %b exp 10", fl); else passed++;
    q.push_back('{12'h049, 2'b10, 2});
    while (q.size() > 0) begin
      e = q.pop_front();
      wait_change(e.dly + 8, c, to);
      total++;
      if (to || c != e.dly || cnt !== e.cnt || fl !== e.fl)
        $display("FAIL resume_step: got %h fl %b after %0d (timeout %0b) exp %h fl %b after %0d", cnt, fl, c, to, e.cnt, e.fl, e.dly);
      else passed++;
    end
    press_clear();
  endtask
  task automatic test_coincident();
    int c;
    bit to;
    load(12'h050);
    press_start();
    tick();
    START = 1'b1;
    STOP = 1'b1;
    CLEAR = 1'b1;
    tick();
    total++; if (cnt !== 12'h000 || fl !== 2'b00) $display("FAIL coincident_clear: got %h fl %b exp 000 fl 00", cnt, fl); else passed++;
    STOP = 1'b0;
    CLEAR = 1'b0;
    PRESET = 12'h050;
    LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    total++; if (cnt !== 12'h050) $display("FAIL held_start_load: got %h exp 050", cnt); else passed++;
    wait_change(50, c, to);
    total++; if (!to || fl !== 2'b00) $display("FAIL held_start_norun: got %h fl %b exp 050 fl 00", cnt, fl); else passed++;
    START = 1'b0;
    tick();
  endtask
  task automatic test_clamp();
    load(12'hAF3);
    total++; if (cnt !== 12'h993) $display("FAIL clamp_load: got %h exp 993", cnt); else passed++;
    press_clear();
    press_start();
    tick();
    total++; if (cnt !== 12'h000 || fl !== 2'b00) $display("FAIL start_zero: got %h fl %b exp 000 fl 00", cnt, fl); else passed++;
  endtask
  task automatic test_back_to_back();
    exp_t e;
    int c;
    bit to;
    load(12'h123);
    PRESET = 12'h456;
    LOAD = 1'b1;
    START = 1'b1;
    tick();
    LOAD = 1'b0;
    START = 1'b0;
    total++; if (cnt !== 12'h123 || fl !== 2'b10) $display("FAIL start_over_load: got %h fl %b exp 123 fl 10", cnt, fl); else passed++;
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    PRESET = 12'h777;
    LOAD = 1'b1;
    tick();
    LOAD = 1'b0;
    total++; if (cnt !== 12'h123 || fl !== 2'b00) $display("FAIL load_in_pause: got %h fl %b exp 123 fl 00", cnt, fl); else passed++;
    press_clear();
    load(12'h100);
    press_start();
    q.push_back('{12'h099, 2'b10, 4});
    q.push_back('{12'h098, 2'b10, 4});
    while (q.size() > 0) begin
      e = q.pop_front();
      wait_change(e.dly + 8, c, to);
      total++;
      if (to || c != e.dly || cnt !== e.cnt || fl !== e.fl)
        $display("FAIL borrow_step: got %h fl %b after %0d (timeout %0b) exp %h fl %b after %0d", cnt, fl, c, to, e.cnt, e.fl, e.dly);
      else passed++;
    end
    press_clear();
  endtask
  task automatic test_async_reset();
    int c;
    bit to;
    load(12'h050);
    press_start();
    tick();
    tick();
    #3;
    RST_N = 1'b0;
    #1;
    total++; if (cnt !== 12'h000 || fl !== 2'b00) $display("FAIL async_reset: got %h fl %b exp 000 fl 00", cnt, fl); else passed++;
    #3;
    RST_N = 1'b1;
    wait_change(20, c, to);
    total++; if (!to || cnt !== 12'h000) $display("FAIL post_reset_idle: got %h fl %b exp 000 fl 00", cnt, fl); else passed++;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish exp finish before 100000");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_load_run();
    test_expire();
    test_pause();
    test_coincident();
    test_clamp();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
